// File: rtl/rambus_wb_responder.sv
// Wishbone classic responder for the shared-RAM bus.
// Holds a DEPTH x 32 word store, answers single-word reads and byte-masked
// writes with a registered one-cycle ack after WAIT_STATES extra cycles.
module rambus_wb_responder #(
   parameter int ADDR_W      = 10,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [ADDR_W-1:0] wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic              busy_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] adr_q;
   logic              we_q;
   logic [3:0]        sel_q;
   logic [31:0]       dat_q;
   logic [31:0]       rdat_q;
   logic              latch;
   logic              commit;

   logic [31:0] mem [DEPTH];

   logic req;
   assign req = wbs_cyc_i & wbs_stb_i;

   // With zero wait states the commit happens on the same edge that samples
   // the request, so the live bus fields are used instead of the latched copy.
   logic              from_bus;
   logic [ADDR_W-1:0] c_adr;
   logic              c_we;
   logic [3:0]        c_sel;
   logic [31:0]       c_dat;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign from_bus = (state_q == S_IDLE);
   assign c_adr    = from_bus ? wbs_adr_i : adr_q;
   assign c_we     = from_bus ? wbs_we_i  : we_q;
   assign c_sel    = from_bus ? wbs_sel_i : sel_q;
   assign c_dat    = from_bus ? wbs_dat_i : dat_q;
   assign in_range = ({1'b0, c_adr} < DEPTH_L);
   assign idx      = c_adr[IDX_W-1:0];

   // Next state, wait counter and the commit strobe (edge entering ACK)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               latch = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WS_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_ACK;
               commit  = 1'b1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter, latched request and read-data registers
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         dat_q   <= 32'd0;
         rdat_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            adr_q <= wbs_adr_i;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
         end
         if (commit && !c_we)
            rdat_q <= in_range ? mem[idx] : 32'd0;
      end
   end

   // Byte-masked write into the store; contents survive reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_ni && commit && c_we && in_range) begin
         for (int b = 0; b < 4; b++)
            if (c_sel[b]) mem[idx][8*b +: 8] <= c_dat[8*b +: 8];
      end
   end

   assign wbs_ack_o = (state_q == S_ACK);
   assign wbs_dat_o = rdat_q;
   assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_rambus_wb_responder.sv
// Bench for rambus_wb_responder: one instance with one wait state, one with
// none. Stimulus pushes expected acks (cycle + read data) into per-instance
// queues; negedge monitors pop and compare whenever ack is seen.
module tb_rambus_wb_responder;

   typedef struct {
      int          cyc;
      bit          rd;
      logic [31:0] dat;
   } sb_t;

   logic        clk = 1'b0;
   int          cyc_n = 0;
   int          checks = 0;
   int          errors = 0;

   logic        rst_s  [2];
   logic        cyc_s  [2];
   logic        stb_s  [2];
   logic        we_s   [2];
   logic [3:0]  sel_s  [2];
   logic [31:0] dati_s [2];
   logic [9:0]  adr_s  [2];
   logic        ack_s  [2];
   logic [31:0] dato_s [2];
   logic        busy_s [2];

   sb_t q0[$];
   sb_t q1[$];
   bit  prev_ack [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   rambus_wb_responder #(.ADDR_W(10), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_s[0]),
      .wbs_cyc_i(cyc_s[0]), .wbs_stb_i(stb_s[0]), .wbs_we_i(we_s[0]),
      .wbs_sel_i(sel_s[0]), .wbs_dat_i(dati_s[0]), .wbs_adr_i(adr_s[0]),
      .wbs_ack_o(ack_s[0]), .wbs_dat_o(dato_s[0]), .busy_o(busy_s[0]));

   rambus_wb_responder #(.ADDR_W(10), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .wb_clk_i(clk), .wb_rst_ni(rst_s[1]),
      .wbs_cyc_i(cyc_s[1]), .wbs_stb_i(stb_s[1]), .wbs_we_i(we_s[1]),
      .wbs_sel_i(sel_s[1]), .wbs_dat_i(dati_s[1]), .wbs_adr_i(adr_s[1]),
      .wbs_ack_o(ack_s[1]), .wbs_dat_o(dato_s[1]), .busy_o(busy_s[1]));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic push(int d, int c, bit rd, logic [31:0] dat);
      sb_t e;
      e.cyc = c; e.rd = rd; e.dat = dat;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic drive(int d, bit we, logic [9:0] adr, logic [3:0] sel, logic [31:0] dat);
      cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = we;
      adr_s[d] = adr;  sel_s[d] = sel;  dati_s[d] = dat;
   endtask

   task automatic idle(int d);
      cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
   endtask

   // Full transfer; called at #1 after a rising edge, returns likewise.
   task automatic xfer(int d, bit we, logic [9:0] adr, logic [3:0] sel,
                       logic [31:0] dat, logic [31:0] exp);
      int ws;
      ws = (d == 0) ? 1 : 0;
      push(d, cyc_n + ws + 1, !we, exp);
      drive(d, we, adr, sel, dat);
      repeat (ws + 1) @(posedge clk);
      #1 idle(d);
      @(posedge clk); #1;
   endtask

   task automatic mon(int d);
      sb_t e;
      if (ack_s[d]) begin
         checks++;
         if (prev_ack[d]) begin
            errors++;
            $display("FAIL ack_twice[%0d] got=ack high two cycles want=single cycle", d);
         end
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_ack[%0d] got=ack at cycle %0d want=no ack", d, cyc_n);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("ack_cycle[%0d]", d), cyc_n, e.cyc);
            if (e.rd) chk($sformatf("rd_data[%0d]", d), dato_s[d], e.dat);
         end
      end
      prev_ack[d] = ack_s[d];
   endtask

   // Scoreboard monitor, sampled away from the rising edge
   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      #200000;
      $display("FAIL timeout got=no finish want=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b0; idle(d); we_s[d] = 1'b0;
         sel_s[d] = 4'h0; dati_s[d] = 32'h0; adr_s[d] = 10'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack_s[0]), 32'd0);
      chk("rst_dat", dato_s[0], 32'd0);
      chk("rst_busy", 32'(busy_s[0]), 32'd0);
      rst_s[0] = 1'b1; rst_s[1] = 1'b1;
      @(posedge clk); #1;

      // 1: write then read back, one wait state
      xfer(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 32'h0);
      xfer(0, 0, 10'h005, 4'hF, 32'h0, 32'hDEADBEEF);

      // 2: byte lanes, then an all-zero mask is a no-op
      xfer(0, 1, 10'h010, 4'hF, 32'h11223344, 32'h0);
      xfer(0, 1, 10'h010, 4'b0101, 32'hAABBCCDD, 32'h0);
      xfer(0, 0, 10'h010, 4'hF, 32'h0, 32'h11BB33DD);
      xfer(0, 1, 10'h010, 4'b0000, 32'hFFFFFFFF, 32'h0);
      xfer(0, 0, 10'h010, 4'hF, 32'h0, 32'h11BB33DD);

      // 3: out of range write dropped (would alias 0x0FF), read returns zero
      xfer(0, 1, 10'h0FF, 4'hF, 32'h55AA55AA, 32'h0);
      xfer(0, 1, 10'h1FF, 4'hF, 32'h12345678, 32'h0);
      chk("dat_held_over_write", dato_s[0], 32'h11BB33DD);
      xfer(0, 0, 10'h1FF, 4'hF, 32'h0, 32'h00000000);
      xfer(0, 0, 10'h0FF, 4'hF, 32'h0, 32'h55AA55AA);

      // 4: abort during WAIT leaves memory untouched
      xfer(0, 1, 10'h020, 4'hF, 32'hCAFEF00D, 32'h0);
      drive(0, 1, 10'h020, 4'hF, 32'h00000000);
      @(posedge clk); #1;
      chk("abort_busy_wait", 32'(busy_s[0]), 32'd1);
      idle(0);
      @(posedge clk); #1;
      chk("abort_busy_fall", 32'(busy_s[0]), 32'd0);
      xfer(0, 0, 10'h020, 4'hF, 32'h0, 32'hCAFEF00D);

      // Inputs changed during WAIT are ignored
      k = cyc_n;
      push(0, k + 2, 1'b0, 32'h0);
      drive(0, 1, 10'h030, 4'hF, 32'h13572468);
      @(posedge clk); #1;
      adr_s[0] = 10'h031; dati_s[0] = 32'h0; sel_s[0] = 4'h0; we_s[0] = 1'b0;
      @(posedge clk); #1;
      idle(0);
      @(posedge clk); #1;
      xfer(0, 0, 10'h030, 4'hF, 32'h0, 32'h13572468);

      // 5: reset during WAIT drops the transfer, memory survives
      xfer(0, 0, 10'h005, 4'hF, 32'h0, 32'hDEADBEEF);
      drive(0, 0, 10'h020, 4'hF, 32'h0);
      @(posedge clk); #1;
      rst_s[0] = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ack", 32'(ack_s[0]), 32'd0);
      chk("midrst_dat", dato_s[0], 32'd0);
      chk("midrst_busy", 32'(busy_s[0]), 32'd0);
      rst_s[0] = 1'b1; idle(0);
      @(posedge clk); #1;
      xfer(0, 0, 10'h005, 4'hF, 32'h0, 32'hDEADBEEF);

      // 6: zero wait states, stb held for back-to-back reads
      xfer(1, 1, 10'h001, 4'hF, 32'h00000111, 32'h0);
      xfer(1, 1, 10'h002, 4'hF, 32'h00000222, 32'h0);
      k = cyc_n;
      push(1, k + 1, 1'b1, 32'h00000111);
      push(1, k + 3, 1'b1, 32'h00000222);
      drive(1, 0, 10'h001, 4'hF, 32'h0);
      @(posedge clk); #1;
      adr_s[1] = 10'h002;
      @(posedge clk); #1;
      chk("b2b_gap_ack", 32'(ack_s[1]), 32'd0);
      @(posedge clk); #1;
      idle(1);
      repeat (3) @(posedge clk);
      #1;

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
